// File: rtl/adder_pkg.sv
// Shared definitions for the prefix adder: operand width, input-stage FSM states
// and the per-bit generate/alive/propagate helper.
package adder_pkg;

    localparam int ADD_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_t;

    // Packed as {g, a, p}, most significant field first.
    function automatic logic [3*ADD_W-1:0] pg_bits(input logic [ADD_W-1:0] x,
                                                   input logic [ADD_W-1:0] y_eff);
        return {x & y_eff, x | y_eff, x ^ y_eff};
    endfunction

endpackage

// File: rtl/pg_cell.sv
// Combinational per-bit generate / alive / propagate from X and the effective Y.
module pg_cell #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y_eff,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] p
);

    assign g = x & y_eff;
    assign a = x | y_eff;
    assign p = x ^ y_eff;

endmodule

// File: rtl/pg_input_stage.sv
// Registered operand front-end of the prefix adder: forms g/a/p/c0 and buffers them
// behind a 2-entry skid buffer so in_ready is a pure decode of registered state.
module pg_input_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    input  logic             op_sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] p_out,
    output logic             c0_out
);

    stage_state_t state, state_nxt;

    logic [WIDTH-1:0] y_eff;
    logic             c_eff;
    logic [WIDTH-1:0] new_g, new_a, new_p;

    logic [WIDTH-1:0] main_g, main_a, main_p;
    logic             main_c0;
    logic [WIDTH-1:0] skid_g, skid_a, skid_p;
    logic             skid_c0;

    logic in_beat, out_beat;
    logic load_main_in, load_main_skid, load_skid;

    // Subtraction is X + ~Y + 1.
    assign y_eff = op_sub ? ~op_y : op_y;
    assign c_eff = op_sub | cin;

    pg_cell #(.WIDTH(WIDTH)) u_pg_cell (
        .x     (op_x),
        .y_eff (y_eff),
        .g     (new_g),
        .a     (new_a),
        .p     (new_p)
    );

    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign in_beat   = in_valid & in_ready;
    assign out_beat  = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (in_beat) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_beat && out_beat) begin
                    load_main_in = 1'b1;
                end else if (in_beat) begin
                    load_skid = 1'b1;
                    state_nxt = ST_SKID;
                end else if (out_beat) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_beat) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_FULL;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            // NOTE: data registers are cleared too, since reset values are visible on g/a/p/c0.
            main_g  <= '0;
            main_a  <= '0;
            main_p  <= '0;
            main_c0 <= 1'b0;
            skid_g  <= '0;
            skid_a  <= '0;
            skid_p  <= '0;
            skid_c0 <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_g  <= new_g;
                main_a  <= new_a;
                main_p  <= new_p;
                main_c0 <= c_eff;
            end else if (load_main_skid) begin
                main_g  <= skid_g;
                main_a  <= skid_a;
                main_p  <= skid_p;
                main_c0 <= skid_c0;
            end
            if (load_skid) begin
                skid_g  <= new_g;
                skid_a  <= new_a;
                skid_p  <= new_p;
                skid_c0 <= c_eff;
            end
        end
    end

    assign g_out  = main_g;
    assign a_out  = main_a;
    assign p_out  = main_p;
    assign c0_out = main_c0;

endmodule

// File: tb/tb_pg_input_stage.sv
// Scoreboard bench for pg_input_stage: expected g/a/p/c0 queued on each accepted
// input beat and compared on each accepted output beat.
module tb_pg_input_stage;

    localparam int W = 32;
    localparam int PW = 3*W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_x, op_y;
    logic         op_sub, cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] g_out, a_out, p_out;
    logic         c0_out;

    int n_vec = 0;
    int n_bad = 0;
    int out_count = 0;

    logic [PW-1:0] sb[$];
    logic [PW-1:0] held;
    logic          prev_stall = 1'b0;

    always #5 clk = ~clk;

    pg_input_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_x      (op_x),
        .op_y      (op_y),
        .op_sub    (op_sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g_out     (g_out),
        .a_out     (a_out),
        .p_out     (p_out),
        .c0_out    (c0_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {g, a, p, c0}
    function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sub, input logic c);
        logic [W-1:0] ye;
        ye = sub ? ~y : y;
        return {x & ye, x | ye, x ^ ye, (sub ? 1'b1 : c)};
    endfunction

    function automatic logic [PW-1:0] dut_word();
        return {g_out, a_out, p_out, c0_out};
    endfunction

    // Monitor: handshakes decided mid-cycle, completed at the next rising edge.
    always @(negedge clk) begin
        logic [PW-1:0] exp;
        if (rst) begin
            sb.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_data", 128'(dut_word()), 128'(held));
            end
            if (out_valid && out_ready) begin
                out_count++;
                if (sb.size() == 0) begin
                    check("spurious_out", 128'(1), 128'(0));
                end else begin
                    exp = sb.pop_front();
                    check("data", 128'(dut_word()), 128'(exp));
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(op_x, op_y, op_sub, cin));
            prev_stall <= out_valid && !out_ready;
            held       <= dut_word();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a beat and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sub, input logic c);
        in_valid = 1'b1;
        op_x = x; op_y = y; op_sub = sub; cin = c;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("send_timeout", 128'(1), 128'(0));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid; i++) tick();
        check("drain_empty", 128'(sb.size()), 128'(0));
        check("drain_valid", 128'(out_valid), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int acc;
        int cyc;
        logic [PW-1:0] b1;

        rst = 1'b1; in_valid = 1'b0; op_x = '0; op_y = '0; op_sub = 1'b0; cin = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_data", 128'(dut_word()), 128'(0));

        // Single add: 1-cycle latency.
        out_ready = 1'b1;
        send(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0);
        check("add_valid", 128'(out_valid), 128'(1));
        check("add_g", 128'(g_out), 128'(32'h1));
        check("add_a", 128'(a_out), 128'(32'hF));
        check("add_p", 128'(p_out), 128'(32'hE));
        check("add_c0", 128'(c0_out), 128'(0));
        tick();

        // Subtract.
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
        check("sub_g", 128'(g_out), 128'(32'h0000_0004));
        check("sub_a", 128'(a_out), 128'(32'hFFFF_FFFD));
        check("sub_p", 128'(p_out), 128'(32'hFFFF_FFF9));
        check("sub_c0", 128'(c0_out), 128'(1));
        tick();

        // Boundaries.
        send('1, '1, 1'b0, 1'b1);
        check("ones_gap", 128'(dut_word()), 128'({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1}));
        send(32'h1234_5678, 32'h0, 1'b1, 1'b0);
        check("sub_y0", 128'(dut_word()),
              128'({32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 1'b1}));
        drain();

        // Backpressure: B1, B2 accepted, B3 stalls.
        out_ready = 1'b0;
        b1 = model(32'hB1, 32'h11, 1'b0, 1'b1);
        send(32'hB1, 32'h11, 1'b0, 1'b1);
        send(32'hB2, 32'h22, 1'b1, 1'b0);
        in_valid = 1'b1; op_x = 32'hB3; op_y = 32'h33; op_sub = 1'b0; cin = 1'b0;
        check("bp_in_ready", 128'(in_ready), 128'(0));
        check("bp_hold_b1", 128'(dut_word()), 128'(b1));
        tick();
        out_ready = 1'b1;
        send(32'hB3, 32'h33, 1'b0, 1'b0);
        drain();

        // Streaming: 16 back-to-back beats.
        base = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("stream_in_ready", 128'(in_ready), 128'(1));
            send(32'(i * 32'h0101_0101), 32'(~i), 1'(i % 3 == 0), 1'(i % 2));
        end
        tick();
        check("stream_count", 128'(out_count - base), 128'(16));
        drain();

        // Reset while in SKID with a beat offered.
        out_ready = 1'b0;
        send(32'hAAAA_0001, 32'h1, 1'b0, 1'b0);
        send(32'hAAAA_0002, 32'h2, 1'b0, 1'b0);
        check("skid_reached", 128'(in_ready), 128'(0));
        rst = 1'b1; in_valid = 1'b1; op_x = 32'hDEAD_BEEF; op_y = 32'h5; op_sub = 1'b0; cin = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("mrst_out_valid", 128'(out_valid), 128'(0));
        check("mrst_in_ready", 128'(in_ready), 128'(1));
        check("mrst_data", 128'(dut_word()), 128'(0));
        base = out_count;
        out_ready = 1'b1;
        repeat (5) tick();
        check("mrst_no_ghost", 128'(out_count - base), 128'(0));

        // Random traffic.
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            op_x   = $urandom();
            op_y   = $urandom();
            op_sub = 1'($urandom_range(1));
            cin    = 1'($urandom_range(1));
            if (in_valid && in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_accepted", 128'(acc), 128'(10000));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
